// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter
//   Shares one synchronous single-port ROM (1-cycle read latency, e.g. the
//   SDFT twiddle table) between N_REQ requesters. Each cycle at most one
//   request is granted, chosen round-robin. The granted address goes straight
//   to the ROM, and the returning data is tagged with the owner's index.
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous reset, active-high
//   req_valid_i   per-requester read request
//   req_addr_i    packed addresses, requester i at [i*AWIDTH +: AWIDTH]
//   req_ready_o   one-hot grant; a transfer happens when valid & ready
//   rom_rdaddr_o  address to the ROM (0 when nothing is granted)
//   rom_rddata_i  ROM data, valid one cycle after the address
//   rsp_valid_o   one-hot response strobe (no backpressure)
//   rsp_id_o      index of the requester owning rsp_data_o
//   rsp_data_o    ROM read data
//
// Configuration
//   ROM_ARB_OUT_REG_EN  when defined, adds one register stage on
//                       rsp_valid_o / rsp_id_o / rsp_data_o (latency t+2).
//                       When undefined, the latency is t+1 and rsp_data_o
//                       passes through combinationally.
module rom_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*AWIDTH-1:0]   req_addr_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [AWIDTH-1:0]         rom_rdaddr_o,
  input  logic [DWIDTH-1:0]         rom_rddata_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [$clog2(N_REQ)-1:0]  rsp_id_o,
  output logic [DWIDTH-1:0]         rsp_data_o
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic [N_REQ-1:0]  grant_vec;
  logic [IDW-1:0]    grant_id;
  logic              grant_any;
  logic [AWIDTH-1:0] grant_addr;
  int                scan_start;
  int                scan_idx;

  // Round-robin scan starting at ptr. Unreachable ptr codes (N_REQ not a
  // power of two) restart the scan at 0. While reset is held, nothing is
  // granted, so no transfer can be recorded.
  always_comb begin
    grant_vec  = '0;
    grant_id   = '0;
    grant_any  = 1'b0;
    grant_addr = '0;
    scan_idx   = 0;
    scan_start = (int'(ptr_q) < N_REQ) ? int'(ptr_q) : 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = scan_start + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!grant_any && req_valid_i[scan_idx]) begin
        grant_any           = 1'b1;
        grant_id            = IDW'(scan_idx);
        grant_vec[scan_idx] = 1'b1;
        grant_addr          = req_addr_i[scan_idx*AWIDTH +: AWIDTH];
      end
    end
    if (rst_i) begin
      grant_any  = 1'b0;
      grant_vec  = '0;
      grant_id   = '0;
      grant_addr = '0;
    end
  end

  assign req_ready_o  = grant_vec;
  assign rom_rdaddr_o = grant_addr;

  // The pointer moves just past the winner, so the winner has the lowest
  // priority next cycle; it holds still when nobody is granted.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = grant_vec;
    rsp_id_d    = rsp_id_q;
    if (grant_any) begin
      ptr_d    = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      rsp_id_d = grant_id;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef ROM_ARB_OUT_REG_EN
  logic [N_REQ-1:0]  out_valid_q, out_valid_d;
  logic [IDW-1:0]    out_id_q, out_id_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;

  // The ROM data lines up with rsp_valid_q, so both enter this stage together.
  always_comb begin
    out_valid_d = rsp_valid_q;
    out_id_d    = rsp_id_q;
    out_data_d  = rom_rddata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= '0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rsp_valid_o = out_valid_q;
  assign rsp_id_o    = out_id_q;
  assign rsp_data_o  = out_data_q;
`else
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rom_rddata_i;
`endif

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Testbench for rom_rr_arbiter (N_REQ=4, AWIDTH=9, DWIDTH=16).
// Provides its own 1-cycle-latency ROM, a round-robin reference model checked
// on every falling edge, and directed scenarios with hand-computed literals.
module tb_rom_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 16;
`ifdef ROM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_rdaddr;
  logic [DW-1:0]   rom_q;
  logic [N-1:0]    rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;

  int checks;
  int failures;

  rom_rr_arbiter #(.N_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .rom_rdaddr_o(rom_rdaddr),
    .rom_rddata_i(rom_q),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The table contents: a scrambled pattern so neighbouring addresses differ.
  function automatic logic [DW-1:0] rom_word(input int a);
    return DW'((a * 40503) ^ 23130);
  endfunction

  // Synchronous ROM: the data for the address presented now appears next cycle.
  always @(posedge clk) rom_q <= rom_word(int'(rom_rdaddr));

  function automatic logic [N*AW-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // Round-robin rule: the first valid requester found scanning upward from p.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after a rising edge; the call returns on the falling
  // edge of that same cycle, when outputs are stable and can be sampled.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    @(negedge clk);
  endtask

  // Reference model state: the rotating priority pointer and a short history
  // of grants, so the responses due LAT cycles later can be predicted.
  int            m_ptr;
  int            st1_g, st1_a, st2_g, st2_a;
  int            mg, og, oa;
  logic [N-1:0]  exp_ready;
  logic [AW-1:0] exp_addr;

  // Every falling edge: compare the grant, the ROM address and the response
  // port with the model, then advance the model as the next rising edge will.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      m_ptr = 0;
      st1_g = -1;
      st2_g = -1;
    end else begin
      mg        = model_grant(req_valid, m_ptr);
      exp_ready = (mg >= 0) ? N'(1 << mg) : '0;
      exp_addr  = (mg >= 0) ? req_addr[mg*AW +: AW] : '0;
      checkOutput("model_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("model_rdaddr", 32'(rom_rdaddr), 32'(exp_addr));
      og = (LAT == 1) ? st1_g : st2_g;
      oa = (LAT == 1) ? st1_a : st2_a;
      checkOutput("model_rsp_valid", 32'(rsp_valid), (og >= 0) ? 32'(1 << og) : 32'h0);
      if (og >= 0) begin
        checkOutput("model_rsp_id", 32'(rsp_id), 32'(og));
        checkOutput("model_rsp_data", 32'(rsp_data), 32'(rom_word(oa)));
      end
      st2_g = st1_g;
      st2_a = st1_a;
      st1_g = mg;
      st1_a = int'(exp_addr);
      if (mg >= 0) m_ptr = (mg + 1) % N;
    end
  end

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = (idx == -1) ? i : -2;
    end
    return idx;
  endfunction

  // Directed scenarios with literal expectations.
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;

    // Reset state, including a grant suppressed while reset is held.
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'h0);
    checkOutput("reset_rdaddr", 32'(rom_rdaddr), 32'h0);
    req_valid = 4'b1111;
    req_addr  = pack(1, 2, 3, 4);
    #1;
    checkOutput("reset_ready_gated", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;

    // All four requesting for 8 cycles: grants and responses rotate 0..3.
    for (int c = 0; c < 8 + LAT; c++) begin
      applyStimulus((c < 8) ? 4'b1111 : 4'b0000, pack(9'h010, 9'h021, 9'h132, 9'h1F3));
      if (c < 8) checkOutput("fair_grant", 32'(onehot_idx(req_ready)), 32'(c % 4));
      if (c >= LAT) begin
        checkOutput("fair_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - LAT) % 4)));
        checkOutput("fair_rsp_id", 32'(rsp_id), 32'((c - LAT) % 4));
      end
    end

    // Single request from requester 2 at address 5.
    applyStimulus(4'b0100, pack(0, 0, 9'h005, 0));
    checkOutput("single_ready", 32'(req_ready), 32'h4);
    checkOutput("single_rdaddr", 32'(rom_rdaddr), 32'h5);
    for (int c = 1; c <= LAT; c++) begin
      applyStimulus(4'b0000, '0);
      if (c == LAT) begin
        checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h4);
        checkOutput("single_rsp_id", 32'(rsp_id), 32'h2);
        checkOutput("single_rsp_data", 32'(rsp_data), 32'(rom_word(5)));
      end
    end

    // Pointer at 3 after granting 2; requesters 0 and 3 -> 3, 0 (wrap), 3.
    applyStimulus(4'b1001, pack(9'h007, 0, 0, 9'h1AB));
    checkOutput("wrap_grant0", 32'(req_ready), 32'h8);
    applyStimulus(4'b1001, pack(9'h007, 0, 0, 9'h1AB));
    checkOutput("wrap_grant1", 32'(req_ready), 32'h1);
    applyStimulus(4'b1001, pack(9'h007, 0, 0, 9'h1AB));
    checkOutput("wrap_grant2", 32'(req_ready), 32'h8);

    // Sole requester 1 streams addresses 0..4 back-to-back.
    for (int c = 0; c < 5 + LAT; c++) begin
      applyStimulus((c < 5) ? 4'b0010 : 4'b0000, pack(0, c, 0, 0));
      if (c < 5) checkOutput("sole_ready", 32'(req_ready), 32'h2);
      if (c >= LAT) begin
        checkOutput("sole_rsp_id", 32'(rsp_id), 32'h1);
        checkOutput("sole_rsp_data", 32'(rsp_data), 32'(rom_word(c - LAT)));
      end
    end

    // Idle cycles leave the pointer at 2, so the next full request picks 2.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0000, pack(9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD));
      checkOutput("idle_ready", 32'(req_ready), 32'h0);
      checkOutput("idle_rdaddr", 32'(rom_rdaddr), 32'h0);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    applyStimulus(4'b1111, pack(9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD));
    checkOutput("after_idle_ready", 32'(req_ready), 32'h4);
    checkOutput("after_idle_rdaddr", 32'(rom_rdaddr), 32'h0CC);

    // Reset one cycle after a grant: the in-flight read is dropped.
    applyStimulus(4'b0010, pack(0, 9'h0C3, 0, 0));
    checkOutput("prerst_ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_addr  = pack(9'h011, 9'h022, 9'h033, 9'h044);
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("midrst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_ready", 32'(req_ready), 32'h1);
    for (int c = 1; c <= LAT + 1; c++) begin
      applyStimulus(4'b0000, '0);
      checkOutput("postrst_rsp_valid", 32'(rsp_valid), (c == LAT) ? 32'h1 : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
